// File: rtl/add_sum_accum.sv
// Frame accumulator behind the 4-bit ripple adder: sums N_SAMPLES {carry,sum} results.
// Define ADD_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module add_sum_accum #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [3:0]       out_cnt
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]   val;
    logic [ACC_W:0]   sum;
    logic [3:0]       cnt;
    logic             ovf;
    logic             xfer;
    logic             last;
    logic             hs;

    assign val  = (ACC_W+1)'({in_carry, in_sum});
    assign sum  = {1'b0, acc} + val;
    assign xfer = in_valid & in_ready;
    assign last = (cnt == 4'(N_SAMPLES - 1));
    assign hs   = out_valid & out_ready;

`ifdef ADD_ACC_SAT_EN
    assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ACCUM: if (xfer && last) next_state = DONE;
            DONE:  if (out_ready)    next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM) & ~clear;
        out_valid = (state == DONE);
    end

    // cnt restarts at completion so out_cnt reads 0 while the frame is held
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else if (state == ACCUM) begin
            if (clear) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (xfer) begin
                acc <= acc_nxt;
                ovf <= ovf | sum[ACC_W];
                if (last) begin
                    cnt     <= '0;
                    out_acc <= acc_nxt;
                    out_ovf <= ovf | sum[ACC_W];
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end else if (hs) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    assign out_cnt = cnt;

endmodule

// File: tb/tb_add_sum_accum.sv
// Bench for add_sum_accum: directed frame tables, corner sequences, and
// randomized traffic against a queue-based frame model (ACC_W=8 and ACC_W=6).
module tb_add_sum_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv[2];
    logic       ir[2];
    logic [3:0] isum[2];
    logic       icar[2];
    logic       clr[2];
    logic       ov[2];
    logic       ordy[2];
    logic       of[2];
    logic [3:0] oc[2];
    logic [7:0] oa0;
    logic [5:0] oa1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    add_sum_accum #(.ACC_W(8), .N_SAMPLES(4)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_sum(isum[0]), .in_carry(icar[0]), .clear(clr[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_acc(oa0), .out_ovf(of[0]), .out_cnt(oc[0])
    );

    add_sum_accum #(.ACC_W(6), .N_SAMPLES(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_sum(isum[1]), .in_carry(icar[1]), .clear(clr[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_acc(oa1), .out_ovf(of[1]), .out_cnt(oc[1])
    );

    typedef struct {
        int v[4];
        int acc;
        int ovf;
    } vec_t;

    function automatic int acc_of(int d);
        return (d == 0) ? int'(oa0) : int'(oa1);
    endfunction

    task automatic chk(string n, int a, int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(int d, int v);
        iv[d] = 1'b1;
        icar[d] = v[4];
        isum[d] = v[3:0];
        #1;
        chk("feed_in_ready", int'(ir[d]), 1);
        tick();
        iv[d] = 1'b0;
    endtask

    task automatic check_frame(string n, int d, int acc, int ovf);
        chk({n, "_valid"}, int'(ov[d]), 1);
        chk({n, "_acc"}, acc_of(d), acc);
        chk({n, "_ovf"}, int'(of[d]), ovf);
    endtask

    // Frame total from the accepted values, using plain integer arithmetic
    task automatic model_frame(int q[$], int w, output int acc, output int ovf);
        int maxv;
        int r;
        maxv = (1 << w) - 1;
        r = 0;
        ovf = 0;
        foreach (q[i]) begin
            r = r + q[i];
            if (r > maxv) begin
                ovf = 1;
`ifdef ADD_ACC_SAT_EN
                r = maxv;
`else
                r = r % (maxv + 1);
`endif
            end
        end
        acc = r;
    endtask

    task automatic run_random(int d, int w, int cycles);
        int q[$];
        bit done;
        int eacc;
        int eovf;
        int v;
        done = 0;
        eacc = 0;
        eovf = 0;
        for (int k = 0; k < cycles; k++) begin
            v = int'($urandom_range(0, 31));
            iv[d] = ($urandom_range(0, 3) != 0);
            clr[d] = ($urandom_range(0, 9) == 0);
            ordy[d] = ($urandom_range(0, 1) == 1);
            icar[d] = v[4];
            isum[d] = v[3:0];
            #1;
            chk("rnd_in_ready", int'(ir[d]), int'(!done && !clr[d]));
            tick();
            if (done) begin
                if (ordy[d]) done = 0;
            end else if (clr[d]) begin
                q.delete();
            end else if (iv[d]) begin
                q.push_back(v);
                if (q.size() == 4) begin
                    model_frame(q, w, eacc, eovf);
                    q.delete();
                    done = 1;
                end
            end
            chk("rnd_out_valid", int'(ov[d]), int'(done));
            chk("rnd_out_cnt", int'(oc[d]), q.size());
            if (done) begin
                chk("rnd_out_acc", acc_of(d), eacc);
                chk("rnd_out_ovf", int'(of[d]), eovf);
            end
        end
        iv[d] = 1'b0;
        clr[d] = 1'b0;
        ordy[d] = 1'b1;
    endtask

    initial begin
        vec_t tbl[4];
        int hold;
        int seen;

        tbl[0] = '{v: '{0, 11, 13, 18}, acc: 42, ovf: 0};
        tbl[1] = '{v: '{31, 31, 31, 31}, acc: 124, ovf: 0};
        tbl[2] = '{v: '{1, 2, 3, 4}, acc: 10, ovf: 0};
        tbl[3] = '{v: '{5, 0, 31, 7}, acc: 43, ovf: 0};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            isum[d] = 4'd0;
            icar[d] = 1'b0;
            clr[d] = 1'b0;
            ordy[d] = 1'b0;
        end

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(ov[0]), 0);
        chk("rst_out_acc", acc_of(0), 0);
        chk("rst_out_ovf", int'(of[0]), 0);
        chk("rst_out_cnt", int'(oc[0]), 0);
        chk("rst_in_ready", int'(ir[0]), 1);
        chk("rst1_in_ready", int'(ir[1]), 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ov[0] || ov[1]) seen++;
        end
        chk("idle_no_valid", seen, 0);

        // Table-driven frames with out_ready held high
        ordy[0] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) feed(0, tbl[t].v[i]);
            check_frame("tbl", 0, tbl[t].acc, tbl[t].ovf);
            tick();
            chk("tbl_valid_drop", int'(ov[0]), 0);
            chk("tbl_ready_back", int'(ir[0]), 1);
        end

        // Backpressure: frame held while in_valid pulses
        ordy[0] = 1'b0;
        for (int i = 0; i < 4; i++) feed(0, 7);
        check_frame("bp", 0, 28, 0);
        hold = acc_of(0);
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1;
            clr[0] = (k == 1);
            isum[0] = 4'd9;
            #1;
            chk("bp_in_ready", int'(ir[0]), 0);
            tick();
            chk("bp_valid", int'(ov[0]), 1);
            chk("bp_acc_hold", acc_of(0), hold);
            chk("bp_cnt", int'(oc[0]), 0);
        end
        iv[0] = 1'b0;
        clr[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp_handshake", int'(ov[0]), 0);
        chk("bp_ready_back", int'(ir[0]), 1);

        // Overflow on the 6-bit instance
        ordy[1] = 1'b1;
        for (int i = 0; i < 4; i++) feed(1, 31);
`ifdef ADD_ACC_SAT_EN
        check_frame("ovf6", 1, 63, 1);
`else
        check_frame("ovf6", 1, 60, 1);
`endif
        tick();
        chk("ovf6_drop", int'(ov[1]), 0);

        // Clear beats a simultaneous in_valid
        feed(0, 3);
        feed(0, 4);
        chk("clr_cnt2", int'(oc[0]), 2);
        iv[0] = 1'b1;
        clr[0] = 1'b1;
        isum[0] = 4'd6;
        #1;
        chk("clr_in_ready", int'(ir[0]), 0);
        tick();
        iv[0] = 1'b0;
        clr[0] = 1'b0;
        chk("clr_cnt0", int'(oc[0]), 0);
        for (int i = 0; i < 4; i++) feed(0, 5);
        check_frame("clr", 0, 20, 0);
        tick();

        // Reset mid-frame discards partial data
        feed(0, 9);
        feed(0, 9);
        feed(0, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_cnt", int'(oc[0]), 0);
        chk("mrst_valid", int'(ov[0]), 0);
        for (int i = 1; i <= 4; i++) feed(0, i);
        check_frame("mrst", 0, 10, 0);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_random(0, 8, 600);
        run_random(1, 6, 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sum_accum.md
Name: add_sum_accum

Overview:
- Sequential stage directly downstream of the 4-bit ripple adder.
- Consumes each 5-bit adder result, made of the 4-bit sum plus the carry-out, through a valid/ready handshake.
- Accumulates N_SAMPLES results into a wider register, then presents the total on an output valid/ready handshake.
- Used for running-sum lab exercises and for self-checking adder sweeps.

Parameters:
- ACC_W, 8, accumulator and out_acc width in bits; legal range 5..16.
- N_SAMPLES, 4, number of adder results summed per output frame; legal range 1..15.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  adder result valid this cycle.
- in_ready  output  1  block can accept an adder result.
- in_sum  input  4  adder sum output.
- in_carry  input  1  adder carry output.
- clear  input  1  synchronous abort of the current partial frame.
- out_valid  output  1  completed frame available.
- out_ready  input  1  consumer accepts the frame.
- out_acc  output  ACC_W  frame total.
- out_ovf  output  1  frame total exceeded the ACC_W range.
- out_cnt  output  4  number of samples accepted in the current partial frame.

Behaviour:
- Operand formation: val = {in_carry, in_sum}, range 0..31, zero-extended to ACC_W+1 bits.
- Sum: sum = acc + val, computed in ACC_W+1 bits.
- FSM has two states:
  - ACCUM: accepting adder results.
  - DONE: holding a completed frame.
- Reset (rst=1 at a clock edge, wins over every other input):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_acc=0, out_ovf=0, out_cnt=0.
  - Reset asserted mid-frame or in DONE discards all data; no frame is emitted.
- in_ready = (state==ACCUM) & ~clear. This is combinational from registered state; no combinational path from in_valid.
- Transfer happens when in_valid & in_ready at a clock edge:
  - acc <= sum[ACC_W-1:0]
  - ovf <= ovf | sum[ACC_W]
  - cnt <= cnt+1
- Frame completion on the transfer where cnt==N_SAMPLES-1:
  - State goes to DONE.
  - out_valid=1, out_acc=final acc, out_ovf=final ovf, all visible the cycle after the edge.
  - Latency is 1 clock from the last transfer to out_valid.
- In DONE:
  - in_ready=0, in_valid is ignored, out_acc/out_ovf are held stable.
  - out_valid stays 1 until out_valid & out_ready at an edge.
  - That handshake returns the FSM to ACCUM with acc=0, cnt=0, ovf=0, out_valid=0.
  - The next input can be accepted on the cycle after the handshake (no bubble-free turnaround).
- clear in ACCUM: acc, cnt and ovf go to 0. clear beats a simultaneous in_valid; no transfer occurs because in_ready=0.
- clear in DONE: ignored; the frame is not dropped.
- out_cnt mirrors the cnt register; it reads 0 in DONE.
- Wrap-around: without the optional feature, acc wraps modulo 2^ACC_W and ovf is sticky for the frame.
- N_SAMPLES=1: every transfer completes a frame.

Optional Feature:
- Macro: ADD_ACC_SAT_EN.
- Defined: when sum[ACC_W]=1, acc saturates to 2^ACC_W-1. It remains saturated for the rest of the frame, and ovf is still set.
- Undefined: modulo wrap as described above.
- Both builds use identical ports and timing.

Test Plan:
- Reset then idle: with rst=1 for 2 cycles, then low, all outputs read 0 except in_ready=1. There is no out_valid for 10 idle cycles.
- Basic frame (defaults, out_ready=1): feed adder results for 0+0, 9+2, 8+5 and 9+9, i.e. {c,s} = 0, 11, 13, {1,0010}=18, one per cycle.
  - One cycle after the 4th transfer: out_valid=1, out_acc=42, out_ovf=0.
  - The next cycle out_valid=0 and in_ready=1.
- Backpressure: complete a frame, then hold out_ready=0 for 3 cycles while pulsing in_valid.
  - in_ready stays 0, out_acc stays constant and out_cnt stays 0.
  - The handshake on cycle 4 clears out_valid.
- Overflow (ACC_W=6): feed four samples of value 31 (in_carry=1, in_sum=4'b1111).
  - Without the macro: out_acc=60, out_ovf=1.
  - With ADD_ACC_SAT_EN: out_acc=63, out_ovf=1.
- Clear and transfer together: after 2 transfers (out_cnt=2), assert clear together with in_valid.
  - in_ready=0, next out_cnt=0.
  - Four further samples of value 5 produce out_acc=20.
- Reset mid-frame: after 3 transfers, pulse rst for 1 cycle.
  - out_cnt=0 and no out_valid.
  - A following frame of 1, 2, 3, 4 gives out_acc=10.
